// File: rtl/mux_pkg.sv
// Shared definitions for the TDM mux/demux pair: FSM states, slot indices
// in {s0,s1} order, and the slot-to-channel one-hot decode.
package mux_pkg;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int NUM_CH = 4;

  localparam logic [1:0] SLOT0 = 2'b00;
  localparam logic [1:0] SLOT1 = 2'b01;
  localparam logic [1:0] SLOT2 = 2'b10;
  localparam logic [1:0] SLOT3 = 2'b11;

  function automatic logic [NUM_CH-1:0] slot_onehot(input logic [1:0] slot);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return one << slot;
  endfunction

endpackage

// File: rtl/demux14_tdm_if.sv
// Serial-lane and channel-output bundle between a TDM sender and the 1:4 demux.
interface demux14_tdm_if #(
   parameter int WIDTH = 8
);
   // din/sof are meaningful only in a cycle where din_valid is high; there is no
   // ready, the demux accepts a beat every cycle. frame_valid/frame_err are
   // single-cycle strobes and d0..d3 are stable between frame_valid pulses.
   logic             din_valid;
   logic [WIDTH-1:0] din;
   logic             sof;
   logic             s0;
   logic             s1;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic             frame_valid;
   logic             frame_err;

   modport master (
      output din_valid, din, sof,
      input  s0, s1, d0, d1, d2, d3, frame_valid, frame_err
   );

   modport slave (
      input  din_valid, din, sof,
      output s0, s1, d0, d1, d2, d3, frame_valid, frame_err
   );
endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter for the TDM demux: clear, load-to-1 on a frame
// start, increment on an in-frame beat; also decodes the shadow write enables.
module tdm_slot_ctr
   import mux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_wr,
   input  logic              i_clr,
   output logic [1:0]        o_slot,
   output logic [NUM_CH-1:0] o_we
);

   logic [1:0] r_slot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= SLOT0;
      end else if (i_clr) begin
         r_slot <= SLOT0;
      end else if (i_start) begin
         r_slot <= SLOT1;
      end else if (i_wr) begin
         r_slot <= r_slot + 2'd1;
      end
   end

   // A frame start always writes channel 0, whatever slot the counter was at.
   always_comb begin
      o_we = '0;
      if (i_start) begin
         o_we = slot_onehot(SLOT0);
      end else if (i_wr) begin
         o_we = slot_onehot(r_slot);
      end
   end

   assign o_slot = r_slot;

endmodule

// File: rtl/demux14_tdm.sv
// Time-division 1:4 demultiplexer: aligns on sof, gathers four beats into
// shadow registers and publishes them atomically on d0..d3.
module demux14_tdm
   import mux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   demux14_tdm_if.slave  bus,
   output logic [0:0]    o_dbg_state
);

   localparam logic [0:0] ST_HUNT    = HUNT;
   localparam logic [0:0] ST_COLLECT = COLLECT;

   logic [0:0]        r_state;
   logic [WIDTH-1:0]  r_sh0, r_sh1, r_sh2;
   logic [WIDTH-1:0]  r_d0, r_d1, r_d2, r_d3;
   logic              r_frame_valid;
   logic              r_frame_err;

   logic [1:0]        w_slot;
   logic [NUM_CH-1:0] w_we;
   logic              w_collect;
   logic              w_slot_nz;
   logic              w_start;
   logic              w_wr;
   logic              w_clr;
   logic              w_err;

   assign w_collect = (r_state == ST_COLLECT);
   assign w_slot_nz = (w_slot != SLOT0);

   // sof always restarts a frame; it is only an error if a frame was partly built.
   assign w_start = bus.din_valid & bus.sof;
   assign w_wr    = bus.din_valid & ~bus.sof & w_collect & w_slot_nz;
   assign w_clr   = bus.din_valid & ~bus.sof & w_collect & ~w_slot_nz;
   assign w_err   = bus.din_valid & w_collect & (bus.sof ? w_slot_nz : ~w_slot_nz);

   tdm_slot_ctr u_slot_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_wr    (w_wr),
      .i_clr   (w_clr),
      .o_slot  (w_slot),
      .o_we    (w_we)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HUNT;
      end else if (w_start) begin
         r_state <= ST_COLLECT;
      end else if (w_clr) begin
         r_state <= ST_HUNT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh0 <= '0;
         r_sh1 <= '0;
         r_sh2 <= '0;
      end else begin
         if (w_we[0]) r_sh0 <= bus.din;
         if (w_we[1]) r_sh1 <= bus.din;
         if (w_we[2]) r_sh2 <= bus.din;
      end
   end

   // The slot-3 write enable doubles as the frame-complete event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d0          <= '0;
         r_d1          <= '0;
         r_d2          <= '0;
         r_d3          <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         if (w_we[3]) begin
            r_d0 <= r_sh0;
            r_d1 <= r_sh1;
            r_d2 <= r_sh2;
            r_d3 <= bus.din;
         end
         r_frame_valid <= w_we[3];
         r_frame_err   <= w_err;
      end
   end

   assign bus.s0          = w_slot[1];
   assign bus.s1          = w_slot[0];
   assign bus.d0          = r_d0;
   assign bus.d1          = r_d1;
   assign bus.d2          = r_d2;
   assign bus.d3          = r_d3;
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_err   = r_frame_err;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_demux14_tdm.sv
// Bench for demux14_tdm: directed vector table, reset corner cases, and random
// traffic checked against a queue-based frame model.
module tb_demux14_tdm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  demux14_tdm_if #(.WIDTH(8)) bus ();

  demux14_tdm #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // reference model: words of the frame being built, alignment, last frame
  logic [7:0] m_q[$];
  bit         m_aligned;
  logic [7:0] m_d[4];
  bit         m_fv;
  bit         m_err;

  task automatic model_reset();
    m_q.delete();
    m_aligned = 0;
    m_fv = 0;
    m_err = 0;
    for (int i = 0; i < 4; i++) m_d[i] = '0;
  endtask

  task automatic model_beat(input logic v, input logic s, input logic [7:0] d);
    m_fv = 0;
    m_err = 0;
    if (v) begin
      if (s) begin
        m_err = (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
        m_aligned = 1;
      end else if (m_aligned) begin
        if (m_q.size() == 0) begin
          m_err = 1;
          m_aligned = 0;
        end else begin
          m_q.push_back(d);
          if (m_q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_d[i] = m_q[i];
            m_q.delete();
            m_fv = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] dut_d();
    return {bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  function automatic logic [31:0] model_d();
    return {m_d[3], m_d[2], m_d[1], m_d[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_fv"},    32'(bus.frame_valid),   32'(m_fv));
    check({tag, "_err"},   32'(bus.frame_err),     32'(m_err));
    check({tag, "_slot"},  32'({bus.s0, bus.s1}),  32'(m_q.size()));
    check({tag, "_d"},     dut_d(),                model_d());
    check({tag, "_state"}, 32'(dbg_state),         32'(m_aligned));
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    bus.din_valid = v;
    bus.sof = s;
    bus.din = d;
    @(posedge clk);
    model_beat(v, s, d);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic        sof;
    logic [7:0]  din;
    logic        exp_fv;
    logic        exp_err;
    logic [1:0]  exp_slot;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl[30];

  initial begin
    // nominal frame, then one idle cycle to see the strobe drop
    tbl[0]  = '{1, 1, 8'hA1, 0, 0, 2'd1, 32'h0};
    tbl[1]  = '{1, 0, 8'hB2, 0, 0, 2'd2, 32'h0};
    tbl[2]  = '{1, 0, 8'hC3, 0, 0, 2'd3, 32'h0};
    tbl[3]  = '{1, 0, 8'hD4, 1, 0, 2'd0, 32'hD4C3B2A1};
    tbl[4]  = '{0, 0, 8'h00, 0, 0, 2'd0, 32'hD4C3B2A1};
    // gapped frame: slot holds while din_valid is low
    tbl[5]  = '{1, 1, 8'h10, 0, 0, 2'd1, 32'hD4C3B2A1};
    tbl[6]  = '{0, 0, 8'h5E, 0, 0, 2'd1, 32'hD4C3B2A1};
    tbl[7]  = '{0, 1, 8'h6F, 0, 0, 2'd1, 32'hD4C3B2A1};
    tbl[8]  = '{0, 0, 8'h7A, 0, 0, 2'd1, 32'hD4C3B2A1};
    tbl[9]  = '{1, 0, 8'h20, 0, 0, 2'd2, 32'hD4C3B2A1};
    tbl[10] = '{0, 0, 8'h99, 0, 0, 2'd2, 32'hD4C3B2A1};
    tbl[11] = '{1, 0, 8'h30, 0, 0, 2'd3, 32'hD4C3B2A1};
    tbl[12] = '{0, 0, 8'h88, 0, 0, 2'd3, 32'hD4C3B2A1};
    tbl[13] = '{1, 0, 8'h40, 1, 0, 2'd0, 32'h40302010};
    // missing sof after a complete frame, then hunt
    tbl[14] = '{1, 0, 8'h77, 0, 1, 2'd0, 32'h40302010};
    tbl[15] = '{0, 0, 8'h00, 0, 0, 2'd0, 32'h40302010};
    tbl[16] = '{1, 0, 8'h11, 0, 0, 2'd0, 32'h40302010};
    tbl[17] = '{1, 0, 8'h22, 0, 0, 2'd0, 32'h40302010};
    tbl[18] = '{1, 1, 8'h33, 0, 0, 2'd1, 32'h40302010};
    tbl[19] = '{1, 0, 8'h44, 0, 0, 2'd2, 32'h40302010};
    tbl[20] = '{1, 0, 8'h55, 0, 0, 2'd3, 32'h40302010};
    tbl[21] = '{1, 0, 8'h66, 1, 0, 2'd0, 32'h66554433};
    // early sof
    tbl[22] = '{1, 1, 8'hAA, 0, 0, 2'd1, 32'h66554433};
    tbl[23] = '{1, 0, 8'hBB, 0, 0, 2'd2, 32'h66554433};
    tbl[24] = '{1, 1, 8'hCC, 0, 1, 2'd1, 32'h66554433};
    tbl[25] = '{1, 0, 8'hDD, 0, 0, 2'd2, 32'h66554433};
    tbl[26] = '{1, 0, 8'hEE, 0, 0, 2'd3, 32'h66554433};
    tbl[27] = '{1, 0, 8'hFF, 1, 0, 2'd0, 32'hFFEEDDCC};
    // back-to-back frame start at slot 0, left at slot 2 for the reset case
    tbl[28] = '{1, 1, 8'h5A, 0, 0, 2'd1, 32'hFFEEDDCC};
    tbl[29] = '{1, 0, 8'h5B, 0, 0, 2'd2, 32'hFFEEDDCC};
  end

  initial begin
    bus.din_valid = 1'b0;
    bus.sof = 1'b0;
    bus.din = '0;
    model_reset();

    // reset held with random traffic on the lane
    for (int i = 0; i < 4; i++) begin
      bus.din_valid = 1'($urandom_range(0, 1));
      bus.sof = 1'($urandom_range(0, 1));
      bus.din = 8'($urandom);
      @(posedge clk);
      #1;
    end
    check_model("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    check_model("rst_rel");

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].v, tbl[i].sof, tbl[i].din);
      check($sformatf("tbl%0d_fv", i),   32'(bus.frame_valid),  32'(tbl[i].exp_fv));
      check($sformatf("tbl%0d_err", i),  32'(bus.frame_err),    32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_slot", i), 32'({bus.s0, bus.s1}), 32'(tbl[i].exp_slot));
      check($sformatf("tbl%0d_d", i),    dut_d(),               tbl[i].exp_d);
    end

    // asynchronous reset in the middle of a frame (currently at slot 2)
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_mid");
    bus.din_valid = 1'b1;
    bus.sof = 1'b0;
    bus.din = 8'h5C;
    @(posedge clk);
    #1;
    check_model("rst_mid_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h5D);
    check_model("rst_mid_after");

    // random traffic against the frame model
    for (int i = 0; i < 600; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_q.size() == 0) s = ($urandom_range(0, 9) < 8);
      else                 s = ($urandom_range(0, 9) < 1);
      step(v, s, 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
